// File: rtl/spart_pkg.sv
`default_nettype none
// ============================================================
// spart_pkg: shared SPART constants and bus register map
// Rev 1.0
// ============================================================
package spart_pkg;

    localparam int SPART_OSR         = 16;
    localparam int SPART_DEFAULT_DIV = 122;
    localparam int SPART_DIV_W       = 16;

    // ioaddr decoding of the SPART bus; DB_LO/DB_HI feed the divisor write strobes
    typedef enum logic [1:0] {
        SPART_ADDR_TXRX   = 2'b00,
        SPART_ADDR_STATUS = 2'b01,
        SPART_ADDR_DB_LO  = 2'b10,
        SPART_ADDR_DB_HI  = 2'b11
    } spart_addr_e;

    // Returns {div_wr_hi, div_wr_lo} for a bus write cycle.
    function automatic logic [1:0] spart_db_strobes(input logic wr, input spart_addr_e addr);
        spart_db_strobes = {wr && (addr == SPART_ADDR_DB_HI), wr && (addr == SPART_ADDR_DB_LO)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spart_mod_counter.sv
`default_nettype none
// ============================================================
// spart_mod_counter: modulo-MOD down-counter with registered wrap pulse
// Rev 1.0
// ============================================================
module spart_mod_counter
    import spart_pkg::*;
#(
    parameter int MOD = SPART_OSR,
    localparam int W  = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         step,
    output logic         wrap_pulse
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         wrap_q, wrap_d;

    // A load always suppresses the pulse, even when it lands on a step.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (load) begin
            cnt_d = load_val;
        end else if (step) begin
            if (cnt_q == '0) begin
                cnt_d  = W'(MOD - 1);
                wrap_d = 1'b1;
            end else begin
                cnt_d = cnt_q - W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= W'(MOD - 1);
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign wrap_pulse = wrap_q;

endmodule
`default_nettype wire

// File: rtl/spart_baud_gen.sv
`default_nettype none
// ============================================================
// spart_baud_gen: SPART oversample tick, tx bit and rx mid-bit enables
// Rev 1.0
// ============================================================
module spart_baud_gen
    import spart_pkg::*;
#(
    parameter int DIV_W       = SPART_DIV_W,
    parameter int OSR         = SPART_OSR,
    parameter int DEFAULT_DIV = SPART_DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             div_wr_lo,
    input  logic             div_wr_hi,
    input  logic [7:0]       div_data,
    input  logic             rx_resync,
    output logic             rx_sample_en,
    output logic             rx_bit_mid,
    output logic             tx_en,
    output logic [DIV_W-1:0] div_value
);

    localparam int PH_W = $clog2(OSR);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       shadow_lo_q, shadow_lo_d;
    logic             rx_sample_en_q, rx_sample_en_d;
    logic [15:0]      div_wr_word;
    logic             tick;
    logic             commit;
    logic             rx_load;
    logic [PH_W-1:0]  rx_load_val;

    assign commit      = div_wr_hi;
    assign tick        = en & (cnt_q == '0);
    // Uses the shadow as it stood before this edge, so a same-cycle lo write lands next time.
    assign div_wr_word = {div_data, shadow_lo_q};

    always_comb begin
        shadow_lo_d    = div_wr_lo ? div_data : shadow_lo_q;
        div_d          = commit ? div_wr_word[DIV_W-1:0] : div_q;
        cnt_d          = cnt_q;
        if (commit) begin
            cnt_d = div_wr_word[DIV_W-1:0];
        end else if (tick) begin
            cnt_d = div_q;
        end else if (en) begin
            cnt_d = cnt_q - DIV_W'(1);
        end
        rx_sample_en_d = tick & ~commit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= DIV_W'(DEFAULT_DIV);
            div_q          <= DIV_W'(DEFAULT_DIV);
            shadow_lo_q    <= 8'(DEFAULT_DIV);
            rx_sample_en_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            div_q          <= div_d;
            shadow_lo_q    <= shadow_lo_d;
            rx_sample_en_q <= rx_sample_en_d;
        end
    end

    // Resync re-centres the rx phase half a bit out; a commit restarts it a full bit out.
    assign rx_load     = commit | rx_resync;
    assign rx_load_val = commit ? PH_W'(OSR - 1) : PH_W'(OSR / 2 - 1);

    spart_mod_counter #(
        .MOD (OSR)
    ) u_tx_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (commit),
        .load_val   (PH_W'(OSR - 1)),
        .step       (tick),
        .wrap_pulse (tx_en)
    );

    spart_mod_counter #(
        .MOD (OSR)
    ) u_rx_ph (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (rx_load),
        .load_val   (rx_load_val),
        .step       (tick),
        .wrap_pulse (rx_bit_mid)
    );

    assign rx_sample_en = rx_sample_en_q;
    assign div_value    = div_q;

endmodule
`default_nettype wire

// File: tb/tb_spart_baud_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================
// tb_spart_baud_gen: scoreboard bench with event-countdown reference model
// Rev 1.0
// ============================================================
module tb_spart_baud_gen;

    localparam int OSR      = 16;
    localparam int DEF_DIV  = 122;
    localparam int DIV_MASK = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst_n, en, div_wr_lo, div_wr_hi, rx_resync;
    logic [7:0]  div_data;
    logic        rx_sample_en, rx_bit_mid, tx_en;
    logic [15:0] div_value;

    spart_baud_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .div_wr_lo    (div_wr_lo),
        .div_wr_hi    (div_wr_hi),
        .div_data     (div_data),
        .rx_resync    (rx_resync),
        .rx_sample_en (rx_sample_en),
        .rx_bit_mid   (rx_bit_mid),
        .tx_en        (tx_en),
        .div_value    (div_value)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        s;
        logic        t;
        logic        m;
        logic [15:0] dv;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: edges remaining until the next event of each kind.
    int m_div, m_shadow, m_to_tick, m_to_tx, m_to_mid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_div     = DEF_DIV;
        m_shadow  = DEF_DIV & 8'hFF;
        m_to_tick = DEF_DIV + 1;
        m_to_tx   = OSR;
        m_to_mid  = OSR;
    endtask

    task automatic model_step();
        obs_t e;
        bit   tick;
        e = '0;
        if (!rst_n) begin
            model_reset();
        end else if (div_wr_hi) begin
            m_div = ((int'(div_data) << 8) | m_shadow) & DIV_MASK;
            if (div_wr_lo) m_shadow = int'(div_data);
            m_to_tick = m_div + 1;
            m_to_tx   = OSR;
            m_to_mid  = OSR;
        end else begin
            if (div_wr_lo) m_shadow = int'(div_data);
            tick = en && (m_to_tick == 1);
            if (tick) m_to_tick = m_div + 1;
            else if (en) m_to_tick--;
            e.s = tick;
            if (tick) begin
                if (m_to_tx == 1) begin e.t = 1'b1; m_to_tx = OSR; end
                else m_to_tx--;
            end
            if (rx_resync) m_to_mid = OSR / 2;
            else if (tick) begin
                if (m_to_mid == 1) begin e.m = 1'b1; m_to_mid = OSR; end
                else m_to_mid--;
            end
        end
        e.dv = 16'(m_div);
        exp_q.push_back(e);
    endtask

    // Monitor: one expected entry per clock edge, compared just after the edge.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_underflow: no expected entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                a = {rx_sample_en, tx_en, rx_bit_mid, div_value};
                check("sb_outputs", 32'(a), 32'(e));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

    task automatic cycle();
        model_step();
        @(negedge clk);
    endtask

    task automatic wait_pulse(input int sel, input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            cycle();
            if ((sel == 0 && rx_sample_en) || (sel == 1 && tx_en) || (sel == 2 && rx_bit_mid)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic write_div(input logic [7:0] lo, input logic [7:0] hi);
        div_wr_lo = 1'b1; div_data = lo; cycle(); div_wr_lo = 1'b0;
        div_wr_hi = 1'b1; div_data = hi; cycle(); div_wr_hi = 1'b0;
    endtask

    task automatic default_timing(input string tag, input bit second_tx);
        int n, total;
        wait_pulse(0, 200, n);
        check({tag, "_first_tick"}, 32'(n), 32'd123);
        total = n;
        wait_pulse(0, 200, n);
        check({tag, "_second_tick"}, 32'(total + n), 32'd246);
        total += n;
        wait_pulse(1, 2000, n);
        check({tag, "_first_tx"}, 32'(total + n), 32'd1968);
        check({tag, "_mid_with_tx"}, 32'(rx_bit_mid), 32'd1);
        if (second_tx) begin
            wait_pulse(1, 2100, n);
            check({tag, "_tx_period"}, 32'(n), 32'd1968);
        end
    endtask

    task automatic async_reset();
        model_step();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_pulses", 32'({rx_sample_en, tx_en, rx_bit_mid}), 32'd0);
        check("async_rst_div", 32'(div_value), 32'(DEF_DIV));
        model_reset();
        @(negedge clk);
    endtask

    initial begin
        int n, total, quiet;
        rst_n = 1'b1; en = 1'b1; div_wr_lo = 1'b0; div_wr_hi = 1'b0;
        div_data = 8'h00; rx_resync = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        check("reset_pulses", 32'({rx_sample_en, tx_en, rx_bit_mid}), 32'd0);
        check("reset_div", 32'(div_value), 32'(DEF_DIV));
        repeat (3) cycle();
        rst_n = 1'b1;

        // Defaults out of reset
        default_timing("s1", 1'b1);

        // div = 3 via lo then hi
        div_wr_lo = 1'b1; div_data = 8'h03; cycle(); div_wr_lo = 1'b0;
        div_wr_hi = 1'b1; div_data = 8'h00; cycle(); div_wr_hi = 1'b0;
        check("s2_div_value", 32'(div_value), 32'd3);
        check("s2_commit_quiet", 32'({rx_sample_en, tx_en, rx_bit_mid}), 32'd0);
        wait_pulse(0, 10, n);
        check("s2_first_tick", 32'(n), 32'd4);
        total = n;
        wait_pulse(1, 100, n);
        check("s2_first_tx", 32'(total + n), 32'd64);
        wait_pulse(1, 100, n);
        check("s2_tx_period", 32'(n), 32'd64);

        // Resync on a tick edge, with div = 3
        repeat (20) cycle();
        for (int i = 0; i < 8 && m_to_tick != 1; i++) cycle();
        rx_resync = 1'b1; cycle(); rx_resync = 1'b0;
        wait_pulse(2, 100, n);
        check("s3_first_mid", 32'(n), 32'd32);
        wait_pulse(2, 100, n);
        check("s3_mid_period", 32'(n), 32'd64);
        repeat (70) cycle();

        // en low while cnt = 10
        write_div(8'd20, 8'h00);
        for (int i = 0; i < 30 && m_to_tick != 11; i++) cycle();
        en = 1'b0;
        quiet = 0;
        for (int i = 0; i < 50; i++) begin
            cycle();
            quiet += int'(rx_sample_en) + int'(tx_en) + int'(rx_bit_mid);
        end
        check("s4_en_low_quiet", 32'(quiet), 32'd0);
        en = 1'b1;
        wait_pulse(0, 30, n);
        check("s4_resume_tick", 32'(n), 32'd11);
        repeat (40) cycle();

        // Simultaneous lo/hi write, then hi-only
        div_wr_lo = 1'b1; div_data = 8'h02; cycle(); div_wr_lo = 1'b0;
        div_wr_lo = 1'b1; div_wr_hi = 1'b1; div_data = 8'h05; cycle();
        div_wr_lo = 1'b0; div_wr_hi = 1'b0;
        check("s5_div_both", 32'(div_value), 32'h0502);
        repeat (5) cycle();
        div_wr_hi = 1'b1; div_data = 8'h00; cycle(); div_wr_hi = 1'b0;
        check("s5_div_hi_only", 32'(div_value), 32'h0005);
        repeat (37) cycle();

        // Asynchronous reset mid-bit
        async_reset();
        repeat (3) cycle();
        rst_n = 1'b1;
        default_timing("s6", 1'b0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            en        = ($urandom_range(0, 9) != 0);
            div_wr_lo = ($urandom_range(0, 19) == 0);
            div_wr_hi = ($urandom_range(0, 49) == 0);
            div_data  = div_wr_hi ? 8'($urandom_range(0, 1)) : 8'($urandom_range(0, 255));
            rx_resync = ($urandom_range(0, 24) == 0);
            cycle();
        end
        en = 1'b1; div_wr_lo = 1'b0; div_wr_hi = 1'b0; rx_resync = 1'b0;
        repeat (2) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
